// File: rtl/text_uart_pkg.sv
// Character constants, FSM state types and UART defaults shared by the text-buffer
// dump path and the receiver-side cursor logic.
package text_uart_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef enum logic [2:0] {
        DUMP_IDLE,
        DUMP_READ,
        DUMP_LATCH,
        DUMP_TX,
        DUMP_CR,
        DUMP_LF,
        DUMP_FINISH
    } dump_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    // Empty cells in the text RAM hold 0x00; show them as blanks on the wire.
    function automatic logic [7:0] printable(input logic [7:0] c);
        return (c == 8'h00) ? CHAR_SPACE : c;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter with a valid/ready byte input.
// Handshake: a byte transfers on a clock where valid_i && ready_o; ready_o is high only
// while idle, and the start bit begins on the following clock.
module uart_tx_serializer
    import text_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign tx_o    = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_o = 1'b0;
        case (state_q)
            SER_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    shreg_d = data_i;
                    cnt_d   = '0;
                    state_d = SER_START;
                end
            end
            SER_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SER_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SER_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = SER_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_d)
            SER_START: tx_d = 1'b0;
            SER_DATA:  tx_d = shreg_d[bit_d];
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/text_buffer_uart_dump.sv
// Scans the text RAM row by row on request and sends every character over UART 8N1,
// optionally terminating each row with CR/LF, so a host can capture the screen contents.
module text_buffer_uart_dump
    import text_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ROWS         = 4,
    parameter int COLS         = 32,
    parameter int ROW_W        = 2,
    parameter int COL_W        = 5,
    parameter int SEND_CRLF    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    input  logic [7:0]       ram_data,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    dump_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       phase_q, phase_d;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;

    assign ram_row = row_q;
    assign ram_col = col_q;
    assign busy    = (state_q != DUMP_IDLE) && (state_q != DUMP_FINISH);
    assign done    = (state_q == DUMP_FINISH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        phase_d  = phase_q;
        tx_valid = 1'b0;
        tx_data  = printable(ram_data);
        case (state_q)
            DUMP_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DUMP_READ;
                end
            end
            DUMP_READ: state_d = DUMP_LATCH;
            DUMP_LATCH: begin
                // Address is held, so ram_data stays valid if the handoff has to wait.
                tx_valid = 1'b1;
                if (tx_ready) state_d = DUMP_TX;
            end
            DUMP_TX: begin
                if (tx_ready) begin
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + COL_W'(1);
                        state_d = DUMP_READ;
                    end else begin
                        col_d = '0;
                        if (SEND_CRLF != 0) begin
                            phase_d = 2'd0;
                            state_d = DUMP_CR;
                        end else if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DUMP_FINISH;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = DUMP_READ;
                        end
                    end
                end
            end
            DUMP_CR, DUMP_LF: begin
                // Phases: 0 spacer (keeps the same inter-frame gap as a RAM read),
                // 1 handoff, 2 wait for the frame to finish.
                tx_data = (state_q == DUMP_CR) ? CHAR_CR : CHAR_LF;
                case (phase_q)
                    2'd0: phase_d = 2'd1;
                    2'd1: begin
                        tx_valid = 1'b1;
                        if (tx_ready) phase_d = 2'd2;
                    end
                    default: begin
                        if (tx_ready) begin
                            phase_d = 2'd0;
                            if (state_q == DUMP_CR) begin
                                state_d = DUMP_LF;
                            end else if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                state_d = DUMP_FINISH;
                            end else begin
                                row_d   = row_q + ROW_W'(1);
                                state_d = DUMP_READ;
                            end
                        end
                    end
                endcase
            end
            DUMP_FINISH: state_d = DUMP_IDLE;
            default:     state_d = DUMP_IDLE;
        endcase
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .reset  (reset),
        .data_i (tx_data),
        .valid_i(tx_valid),
        .ready_o(tx_ready),
        .tx_o   (tx)
    );

endmodule

// File: tb/tb_text_buffer_uart_dump.sv
// Directed bench: two dump instances (with and without CR/LF) read a shared model text RAM;
// a UART monitor decodes each tx line into a received-byte queue.
module tb_text_buffer_uart_dump;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [1:0] row_a, row_b;
    logic [4:0] col_a, col_b;
    logic [7:0] rd_a, rd_b;
    logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] ram [4][32];

    logic [1:0] txs, dones, busys;
    assign txs   = {tx_b, tx_a};
    assign dones = {done_b, done_a};
    assign busys = {busy_b, busy_a};

    always #5 clk = ~clk;

    // Model RAM: registered read, data valid one clock after the address.
    always @(posedge clk) begin
        rd_a <= ram[row_a][col_a];
        rd_b <= ram[row_b][col_b];
    end

    text_buffer_uart_dump #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ram_row(row_a), .ram_col(col_a),
        .ram_data(rd_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    text_buffer_uart_dump #(.CLKS_PER_BIT(CPB), .SEND_CRLF(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ram_row(row_b), .ram_col(col_b),
        .ram_data(rd_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // UART monitor: sample index 0 is the first low sample of the start bit; bits are
    // taken mid-bit at 4n+2, stop bit at 38.
    logic       m_act [2];
    int         m_n [2];
    logic [7:0] m_byte [2];
    int         frame_err [2];
    int         done_cycles [2];
    int         done_busy [2];
    logic [7:0] rx_a [$];
    logic [7:0] rx_b [$];

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k]       <= 1'b0;
                m_n[k]         <= 0;
                frame_err[k]   <= 0;
                done_cycles[k] <= 0;
                done_busy[k]   <= 0;
            end
            rx_a.delete();
            rx_b.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (dones[k]) begin
                    done_cycles[k] <= done_cycles[k] + 1;
                    if (busys[k]) done_busy[k] <= done_busy[k] + 1;
                end
                if (!m_act[k]) begin
                    if (txs[k] === 1'b0) begin
                        m_act[k] <= 1'b1;
                        m_n[k]   <= 1;
                    end
                end else begin
                    m_n[k] <= m_n[k] + 1;
                    if (m_n[k] == 2 && txs[k] !== 1'b0) frame_err[k] <= frame_err[k] + 1;
                    if (m_n[k] % 4 == 2 && m_n[k] >= 6 && m_n[k] <= 34)
                        m_byte[k][(m_n[k] - 6) / 4] <= txs[k];
                    if (m_n[k] == 38) begin
                        if (txs[k] !== 1'b1) frame_err[k] <= frame_err[k] + 1;
                        if (k == 0) rx_a.push_back(m_byte[k]);
                        else        rx_b.push_back(m_byte[k]);
                    end
                    if (m_n[k] == 39) m_act[k] <= 1'b0;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic       fin_a, fin_b;

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                ram[r][c] = 8'h00;
        ram[0][0]  = 8'h41;
        ram[0][1]  = 8'h42;
        ram[1][0]  = 8'h7A;
        ram[2][5]  = 8'h31;
        ram[3][31] = 8'h7E;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_row_a", row_a, 0);
        check("rst_col_a", col_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_busy_b", busy_b, 0);
        check("rst_done_b", done_b, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 32; c++) begin
                exp_a.push_back((ram[r][c] == 8'h00) ? 8'h20 : ram[r][c]);
                exp_b.push_back((ram[r][c] == 8'h00) ? 8'h20 : ram[r][c]);
            end
            exp_a.push_back(8'h0D);
            exp_a.push_back(8'h0A);
        end

        // ---- full dumps: A with CR/LF (1-clk start), B without CR/LF (start toggling) ----
        start_a = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_a_after_start", busy_a, 1);
        check("busy_b_after_start", busy_b, 1);
        fin_a = 1'b0;
        fin_b = 1'b0;
        for (int i = 0; i < 8000 && !(fin_a && fin_b); i++) begin
            if (done_a) fin_a = 1'b1;
            if (done_b) fin_b = 1'b1;
            start_b = fin_b ? 1'b0 : ~start_b;
            @(negedge clk);
        end
        start_b = 1'b0;
        check("dump_a_finished", fin_a, 1);
        check("dump_b_finished", fin_b, 1);
        repeat (60) @(negedge clk);
        check("idle_busy_a", busy_a, 0);
        check("idle_busy_b", busy_b, 0);
        check("frames_a", rx_a.size(), 136);
        check("frames_b", rx_b.size(), 128);
        check("rx_a_first", (rx_a.size() > 0) ? rx_a[0] : 8'hxx, 8'h41);
        check("rx_a_second", (rx_a.size() > 1) ? rx_a[1] : 8'hxx, 8'h42);
        check("rx_a_nul_space", (rx_a.size() > 2) ? rx_a[2] : 8'hxx, 8'h20);
        check("rx_a_row0_cr", (rx_a.size() > 32) ? rx_a[32] : 8'hxx, 8'h0D);
        check("rx_a_row0_lf", (rx_a.size() > 33) ? rx_a[33] : 8'hxx, 8'h0A);
        check("rx_a_row1_first", (rx_a.size() > 34) ? rx_a[34] : 8'hxx, 8'h7A);
        check("rx_a_last_char", (rx_a.size() > 133) ? rx_a[133] : 8'hxx, 8'h7E);
        check("rx_a_last_cr", (rx_a.size() > 134) ? rx_a[134] : 8'hxx, 8'h0D);
        check("rx_a_last_lf", (rx_a.size() > 135) ? rx_a[135] : 8'hxx, 8'h0A);
        check("rx_b_row1_first", (rx_b.size() > 32) ? rx_b[32] : 8'hxx, 8'h7A);
        check("rx_b_last", (rx_b.size() > 127) ? rx_b[127] : 8'hxx, 8'h7E);
        for (int i = 0; i < exp_a.size() && i < rx_a.size(); i++)
            check($sformatf("rx_a[%0d]", i), rx_a[i], exp_a[i]);
        for (int i = 0; i < exp_b.size() && i < rx_b.size(); i++)
            check($sformatf("rx_b[%0d]", i), rx_b[i], exp_b[i]);
        check("done_a_width", done_cycles[0], 1);
        check("done_b_width", done_cycles[1], 1);
        check("busy_a_at_done", done_busy[0], 0);
        check("busy_b_at_done", done_busy[1], 0);
        check("frame_err_a", frame_err[0], 0);
        check("frame_err_b", frame_err[1], 0);
        check("end_row_a", row_a, 0);
        check("end_col_a", col_a, 0);
        check("end_row_b", row_b, 0);
        check("end_col_b", col_b, 0);

        // ---- reset mid-frame, then restart ----
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (300) @(negedge clk);
        for (int i = 0; i < 100 && tx_a !== 1'b0; i++) @(negedge clk);
        check("tx_low_before_reset", tx_a, 0);
        reset = 1'b1;
        #1;
        check("async_rst_tx", tx_a, 1);
        check("async_rst_busy", busy_a, 0);
        check("async_rst_done", done_a, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_row", row_a, 0);
        check("rst_hold_col", col_a, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle_tx", tx_a, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_row", row_a, 0);
        check("restart_col", col_a, 0);
        fin_a = 1'b0;
        for (int i = 0; i < 8000 && !fin_a; i++) begin
            if (done_a) fin_a = 1'b1;
            @(negedge clk);
        end
        check("redump_finished", fin_a, 1);
        repeat (60) @(negedge clk);
        check("redump_frames", rx_a.size(), 136);
        check("redump_first", (rx_a.size() > 0) ? rx_a[0] : 8'hxx, 8'h41);
        check("redump_second", (rx_a.size() > 1) ? rx_a[1] : 8'hxx, 8'h42);
        check("redump_last_char", (rx_a.size() > 133) ? rx_a[133] : 8'hxx, 8'h7E);
        check("redump_done_width", done_cycles[0], 1);
        check("redump_frame_err", frame_err[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
